// File: rtl/bsu_pkg.sv
// Shared definitions for the beam-steering select sequencer: decoder select codes,
// FSM state encoding and channel-scan helper functions.
package bsu_pkg;

  localparam int unsigned NCHAN = 4;

  localparam logic [4:0] SEL_IDLE = 5'b00000;
  localparam logic [4:0] SEL_CH0  = 5'b00110;
  localparam logic [4:0] SEL_CH1  = 5'b01010;
  localparam logic [4:0] SEL_CH2  = 5'b01110;
  localparam logic [4:0] SEL_CH3  = 5'b10010;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_DWELL,
    ST_GAP,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic       wrap;
    logic [1:0] chan;
  } next_t;

  function automatic logic [4:0] chan2sel(input logic [1:0] k);
    logic [4:0] s;
    case (k)
      2'd0:    s = SEL_CH0;
      2'd1:    s = SEL_CH1;
      2'd2:    s = SEL_CH2;
      default: s = SEL_CH3;
    endcase
    return s;
  endfunction

  // Lowest masked channel >= ptr; if none, lowest masked channel with wrap set.
  function automatic next_t next_chan(input logic [3:0] mask, input logic [2:0] ptr);
    next_t r;
    logic  hit_hi;
    logic  hit_lo;
    r      = '{wrap: 1'b1, chan: 2'd0};
    hit_hi = 1'b0;
    hit_lo = 1'b0;
    for (int unsigned i = 0; i < NCHAN; i++) begin
      if (!hit_hi && mask[i] && (i >= 32'(ptr))) begin
        hit_hi = 1'b1;
        r.chan = 2'(i);
        r.wrap = 1'b0;
      end
    end
    for (int unsigned i = 0; i < NCHAN; i++) begin
      if (!hit_hi && !hit_lo && mask[i]) begin
        hit_lo = 1'b1;
        r.chan = 2'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bsu_dwell_timer.sv
// Loadable down-counter with zero flag; times both the dwell and the guard gap.
module bsu_dwell_timer
  import bsu_pkg::*;
#(
  parameter int unsigned DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               en,
  input  logic [DWELL_W-1:0] load_val,
  output logic               zero
);

  logic [DWELL_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - DWELL_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/bsu_sel_sequencer.sv
// Break-before-make channel scanner driving the 4-way select decoder (en/sel).
// Optional decoder loopback check enabled by defining BSU_SEL_LOOPBACK_EN.
module bsu_sel_sequencer
  import bsu_pkg::*;
#(
  parameter int unsigned DWELL_W = 16,
  parameter int unsigned GAP_CYC = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               abort,
  input  logic [3:0]         chan_mask,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               cont,
  input  logic [3:0]         f_in,
  output logic               en,
  output logic [4:0]         sel,
  output logic [1:0]         cur_chan,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               lb_err
);

  state_t             state, state_n;
  logic [3:0]         mask_q;
  logic [DWELL_W-1:0] dwell_q;
  logic               cont_q;
  logic               stop_pend, stop_n;
  logic               en_n, busy_n, done_n, err_n;
  logic [4:0]         sel_n;
  logic [1:0]         chan_n;
  logic               accept;
  logic               tmr_load, tmr_en, tmr_zero;
  logic [DWELL_W-1:0] tmr_val;
  next_t              first, nxt;

  bsu_dwell_timer #(.DWELL_W(DWELL_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .en       (tmr_en),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // Outputs are computed for the next state and registered, so sel only moves
  // on entry to SETUP or DONE, both of which follow an en-low cycle.
  always_comb begin
    state_n  = state;
    en_n     = 1'b0;
    sel_n    = sel;
    busy_n   = busy;
    done_n   = 1'b0;
    err_n    = 1'b0;
    chan_n   = cur_chan;
    stop_n   = stop_pend | (stop && (state != ST_IDLE));
    accept   = 1'b0;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;
    tmr_val  = dwell_q - DWELL_W'(1);
    first    = next_chan(chan_mask, 3'd0);
    nxt      = next_chan(mask_q, {1'b0, cur_chan} + 3'd1);

    case (state)
      ST_IDLE: begin
        busy_n = 1'b0;
        sel_n  = SEL_IDLE;
        stop_n = 1'b0;
        if (start) begin
          if ((chan_mask == '0) || (dwell == '0)) begin
            err_n = 1'b1;
          end else begin
            accept  = 1'b1;
            state_n = ST_SETUP;
            busy_n  = 1'b1;
            chan_n  = first.chan;
            sel_n   = chan2sel(first.chan);
          end
        end
      end
      ST_SETUP: begin
        state_n  = ST_DWELL;
        en_n     = 1'b1;
        tmr_load = 1'b1;
      end
      ST_DWELL: begin
        if (tmr_zero) begin
          state_n  = ST_GAP;
          tmr_load = 1'b1;
          tmr_val  = DWELL_W'(GAP_CYC - 1);
        end else begin
          en_n   = 1'b1;
          tmr_en = 1'b1;
        end
      end
      ST_GAP: begin
        if (tmr_zero) begin
          if (stop_n || (nxt.wrap && !cont_q)) begin
            state_n = ST_DONE;
            sel_n   = SEL_IDLE;
            done_n  = 1'b1;
          end else begin
            state_n = ST_SETUP;
            chan_n  = nxt.chan;
            sel_n   = chan2sel(nxt.chan);
          end
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
        busy_n  = 1'b0;
        stop_n  = 1'b0;
      end
      default: begin
        state_n = ST_IDLE;
        busy_n  = 1'b0;
        sel_n   = SEL_IDLE;
      end
    endcase

    if (abort) begin
      state_n  = ST_IDLE;
      en_n     = 1'b0;
      sel_n    = SEL_IDLE;
      busy_n   = 1'b0;
      done_n   = 1'b0;
      err_n    = 1'b0;
      stop_n   = 1'b0;
      accept   = 1'b0;
      chan_n   = cur_chan;
      tmr_load = 1'b0;
      tmr_en   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      en        <= 1'b0;
      sel       <= SEL_IDLE;
      cur_chan  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      stop_pend <= 1'b0;
      mask_q    <= '0;
      dwell_q   <= '0;
      cont_q    <= 1'b0;
    end else begin
      state     <= state_n;
      en        <= en_n;
      sel       <= sel_n;
      cur_chan  <= chan_n;
      busy      <= busy_n;
      done      <= done_n;
      err       <= err_n;
      stop_pend <= stop_n;
      if (accept) begin
        mask_q  <= chan_mask;
        dwell_q <= dwell;
        cont_q  <= cont;
      end
    end
  end

`ifdef BSU_SEL_LOOPBACK_EN
  logic dwell_first;
  logic lb_bad;

  // The decoder needs one cycle to follow en, so the first DWELL cycle is not checked.
  always_comb begin
    lb_bad = 1'b0;
    case (state)
      ST_DWELL:                   lb_bad = !dwell_first && (f_in != (4'b0001 << cur_chan));
      ST_SETUP, ST_GAP, ST_IDLE:  lb_bad = (f_in != 4'b0000);
      default:                    lb_bad = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dwell_first <= 1'b0;
      lb_err      <= 1'b0;
    end else begin
      dwell_first <= (state == ST_SETUP);
      if (accept) begin
        lb_err <= 1'b0;
      end else if (lb_bad) begin
        lb_err <= 1'b1;
      end
    end
  end
`else
  logic unused_fin;
  assign unused_fin = ^f_in;
  assign lb_err     = 1'b0;
`endif

endmodule
